// File: rtl/video_timing_pkg.sv
// Shared timing constants, count width and lock-state encoding for the video
// sync receiver.
package video_timing_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned PIX_W = 12;
  localparam int unsigned SUM_W = 16;

  localparam int unsigned H_ACT_DEF = 800;
  localparam int unsigned V_ACT_DEF = 600;
  localparam int unsigned H_BP_DEF  = 88;
  localparam int unsigned V_BP_DEF  = 23;

  localparam int unsigned H_TOT_NOM = 1056;
  localparam int unsigned V_TOT_NOM = 628;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    SEARCH,
    MEASURE,
    LOCKED
  } sync_state_t;

endpackage

// File: rtl/video_sync_rx_edge_det.sv
// One-stage sync register with a same-cycle falling-edge pulse
// (registered level high, live input low).
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic fall_c
);

  logic q;

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= sig;
  end

  assign fall_c = q & ~sig;

endmodule

// File: rtl/video_sync_rx.sv
// Video sync receiver: locks to incoming hsync/vsync timing and emits
// per-pixel write strobes with recovered x/y. Optional per-frame checksum
// built when VIDEO_SYNC_RX_CHECKSUM_EN is defined.
module video_sync_rx
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACT = H_ACT_DEF,
  parameter int unsigned V_ACT = V_ACT_DEF,
  parameter int unsigned H_BP  = H_BP_DEF,
  parameter int unsigned V_BP  = V_BP_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [PIX_W-1:0] pix_in,
  output logic             pix_valid,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic [PIX_W-1:0] pix_data,
  output logic             frame_start,
  output logic             locked,
  output logic [CNT_W-1:0] line_len,
  output logic [CNT_W-1:0] frame_lines,
  output logic             timing_err,
  output logic [SUM_W-1:0] frame_sum
);

  localparam cnt_t CNT_MAX = '1;
  localparam cnt_t H_LO    = CNT_W'(H_BP);
  localparam cnt_t H_HI    = CNT_W'(H_BP + H_ACT);
  localparam cnt_t V_LO    = CNT_W'(V_BP);
  localparam cnt_t V_HI    = CNT_W'(V_BP + V_ACT);

  logic        hs_fall_c;
  logic        vs_fall_c;
  cnt_t        hcnt;
  cnt_t        vcnt;
  sync_state_t state;
  sync_state_t state_nxt;
  logic        meas_first;
  logic        cap_line_c;
  logic        cap_frame_c;
  logic        err_c;
  logic        sat_c;
  logic        act_c;

  sync_edge_det u_hs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig    (hsync_in),
    .fall_c (hs_fall_c)
  );

  sync_edge_det u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .sig    (vsync_in),
    .fall_c (vs_fall_c)
  );

  // Saturating position counters; a coincident vsync fall clears vcnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt <= '0;
      vcnt <= '0;
    end else begin
      if (hs_fall_c)            hcnt <= '0;
      else if (hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);

      if (vs_fall_c)                          vcnt <= '0;
      else if (hs_fall_c && vcnt != CNT_MAX)  vcnt <= vcnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      meas_first <= 1'b1;
    end else begin
      state      <= state_nxt;
      meas_first <= (state != MEASURE) | (meas_first & ~hs_fall_c);
    end
  end

  always_comb begin
    state_nxt   = state;
    cap_line_c  = 1'b0;
    cap_frame_c = 1'b0;
    err_c       = 1'b0;
    sat_c       = (hcnt == CNT_MAX) || (vcnt == CNT_MAX);
    act_c       = (state == LOCKED) &&
                  (hcnt >= H_LO) && (hcnt < H_HI) &&
                  (vcnt >= V_LO) && (vcnt < V_HI);
    case (state)
      SEARCH: begin
        if (vs_fall_c) state_nxt = MEASURE;
      end
      MEASURE: begin
        cap_line_c = hs_fall_c && meas_first;
        if (sat_c || (hs_fall_c && !meas_first && hcnt != line_len)) begin
          state_nxt = SEARCH;
        end else if (vs_fall_c) begin
          state_nxt   = LOCKED;
          cap_frame_c = 1'b1;
        end
      end
      LOCKED: begin
        if (sat_c || (hs_fall_c && hcnt != line_len) ||
            (vs_fall_c && vcnt != frame_lines)) begin
          state_nxt = SEARCH;
          err_c     = 1'b1;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
      timing_err  <= 1'b0;
    end else begin
      pix_valid   <= act_c;
      pix_data    <= pix_in;
      frame_start <= act_c && (hcnt == H_LO) && (vcnt == V_LO);
      locked      <= (state_nxt == LOCKED);
      timing_err  <= err_c;
      if (act_c) begin
        pix_x <= hcnt - H_LO;
        pix_y <= vcnt - V_LO;
      end
      if (cap_line_c)  line_len    <= hcnt;
      if (cap_frame_c) frame_lines <= vcnt;
    end
  end

`ifdef VIDEO_SYNC_RX_CHECKSUM_EN
  logic [SUM_W-1:0] acc;

  // Sum of strobed pixels, handed over at each locked frame boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      frame_sum <= '0;
    end else if (state != LOCKED || err_c) begin
      acc <= '0;
    end else if (vs_fall_c) begin
      frame_sum <= acc;
      acc       <= '0;
    end else if (pix_valid) begin
      acc <= acc + SUM_W'(pix_data);
    end
  end
`else
  assign frame_sum = '0;
`endif

endmodule

// File: tb/tb_video_sync_rx.sv
// Directed bench for video_sync_rx on a reduced 32x16 raster (16x8 active,
// H_BP 6, V_BP 3) with hand-computed expectations.
module tb_video_sync_rx;
  import video_timing_pkg::*;

  localparam int HA = 16, VA = 8, HB = 6, VB = 3;
  localparam int HT = 32, VT = 16, HS_W = 8, VS_L = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             hsync_in, vsync_in;
  logic [PIX_W-1:0] pix_in;
  logic             pix_valid, frame_start, locked, timing_err;
  logic [CNT_W-1:0] pix_x, pix_y, line_len, frame_lines;
  logic [PIX_W-1:0] pix_data;
  logic [SUM_W-1:0] frame_sum;

  always #5 clk = ~clk;

  video_sync_rx #(.H_ACT(HA), .V_ACT(VA), .H_BP(HB), .V_BP(VB)) dut (
    .clk         (clk),
    .rst         (rst),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .pix_in      (pix_in),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_data    (pix_data),
    .frame_start (frame_start),
    .locked      (locked),
    .line_len    (line_len),
    .frame_lines (frame_lines),
    .timing_err  (timing_err),
    .frame_sum   (frame_sum)
  );

  int n_checks = 0;
  int n_errors = 0;
  int gh, gv, short_v;
  bit blank;
  int strobes, bad, fs_cnt, err_seen;
  int first_x, first_y, first_fs, last_x, last_y;
  bit got_first;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input int v);
    return (v == short_v) ? HT - 4 : HT;
  endfunction

  function automatic bit in_win(input int h, input int v);
    return (h >= HB + 1) && (h <= HB + HA) && (v >= VB) && (v < VB + VA);
  endfunction

  function automatic logic [11:0] pat(input int x, input int y);
    logic [7:0] xb, yb;
    xb = 8'(x);
    yb = 8'(y);
    return {xb[3:0], yb[3:0], xb[7:4]};
  endfunction

  task automatic drive();
    hsync_in = blank ? 1'b0 : 1'(gh >= len_of(gv) - HS_W);
    vsync_in = blank ? 1'b0 : 1'(gv >= VT - VS_L);
    pix_in   = in_win(gh, gv) ? pat(gh - HB - 1, gv - VB) : 12'h000;
  endtask

  task automatic clear_mon();
    strobes = 0; bad = 0; fs_cnt = 0; err_seen = 0; got_first = 0;
    first_x = -1; first_y = -1; first_fs = 0; last_x = -1; last_y = -1;
  endtask

  // Compares each strobe against the raster position that was clocked in.
  task automatic monitor();
    int ex, ey;
    if (timing_err) err_seen++;
    if (pix_valid) begin
      strobes++;
      ex = gh - HB - 1;
      ey = gv - VB;
      if (!in_win(gh, gv) || pix_x != 11'(ex) || pix_y != 11'(ey) ||
          pix_data != pat(ex, ey) || frame_start != 1'(ex == 0 && ey == 0))
        bad++;
      if (!got_first) begin
        got_first = 1;
        first_x   = int'(pix_x);
        first_y   = int'(pix_y);
        first_fs  = int'(frame_start);
      end
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      if (frame_start) fs_cnt++;
    end else if (frame_start) begin
      bad++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
    if (gh == len_of(gv) - 1) begin
      gh = 0;
      gv = (gv == VT - 1) ? 0 : gv + 1;
    end else begin
      gh++;
    end
    drive();
  endtask

  task automatic run_until(input int v, input int h);
    int n = 0;
    while (!(gv == v && gh == h) && n < 4000) begin
      tick();
      n++;
    end
    check("run_until_bound", 32'(n >= 4000), 32'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_pix_valid"},   32'(pix_valid),   32'd0);
    check({pfx, "_pix_x"},       32'(pix_x),       32'd0);
    check({pfx, "_pix_y"},       32'(pix_y),       32'd0);
    check({pfx, "_pix_data"},    32'(pix_data),    32'd0);
    check({pfx, "_frame_start"}, 32'(frame_start), 32'd0);
    check({pfx, "_locked"},      32'(locked),      32'd0);
    check({pfx, "_line_len"},    32'(line_len),    32'd0);
    check({pfx, "_frame_lines"}, 32'(frame_lines), 32'd0);
    check({pfx, "_timing_err"},  32'(timing_err),  32'd0);
    check({pfx, "_frame_sum"},   32'(frame_sum),   32'd0);
  endtask

  initial begin
    rst = 1'b1; gh = 10; gv = 5; short_v = -1; blank = 0;
    drive();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    clear_mon();

    // Lock: MEASURE after the first vsync fall, LOCKED after the second.
    run_until(0, 0); tick();
    check("lock_after_1st_vs", 32'(locked), 32'd0);
    run_until(0, 0); tick();
    check("lock_after_2nd_vs", 32'(locked), 32'd1);
    check("line_len",    32'(line_len),    32'd31);
    check("frame_lines", 32'(frame_lines), 32'd15);
    check("strobes_before_lock", 32'(strobes), 32'd0);

    // First locked frame: 16x8 strobes, (0,0) with frame_start, ends (15,7).
    clear_mon();
    run_until(0, 0);
    check("frame_strobes", 32'(strobes), 32'd128);
    check("frame_bad_strobes", 32'(bad), 32'd0);
    check("frame_start_cnt", 32'(fs_cnt), 32'd1);
    check("first_x", 32'(first_x), 32'd0);
    check("first_y", 32'(first_y), 32'd0);
    check("first_frame_start", 32'(first_fs), 32'd1);
    check("last_x", 32'(last_x), 32'd15);
    check("last_y", 32'(last_y), 32'd7);
    check("no_err_locked", 32'(err_seen), 32'd0);
    tick();
    check("still_locked", 32'(locked), 32'd1);
`ifdef VIDEO_SYNC_RX_CHECKSUM_EN
    // 8 rows * (0+..+15) << 8  +  16 cols * (0+..+7) << 4 = 252928 -> 16'hDC00
    check("frame_sum", 32'(frame_sum), 32'h0000DC00);
`else
    check("frame_sum_off", 32'(frame_sum), 32'd0);
`endif

    // Short line (28 clocks) on raster line 4.
    run_until(4, 0);
    short_v = 4;
    drive();
    run_until(5, 0);
    check("short_pre_err",  32'(timing_err), 32'd0);
    check("short_pre_lock", 32'(locked),     32'd1);
    tick();
    check("short_err",    32'(timing_err), 32'd1);
    check("short_unlock", 32'(locked),     32'd0);
    tick();
    check("short_err_pulse", 32'(timing_err), 32'd0);
    short_v = -1;
    clear_mon();
    run_until(0, 0); tick();
    check("short_relock_1st", 32'(locked), 32'd0);
    run_until(0, 0); tick();
    check("short_relock_2nd", 32'(locked), 32'd1);
    check("short_no_strobes", 32'(strobes), 32'd0);
    check("short_no_more_err", 32'(err_seen), 32'd0);

    // Sync loss: hcnt saturates 2048 cycles after the last hsync fall.
    run_until(2, 0);
    blank = 1;
    drive();
    clear_mon();
    repeat (2048) tick();
    check("sat_early_err", 32'(err_seen), 32'd0);
    check("sat_hold_lock", 32'(locked), 32'd1);
    tick();
    check("sat_err",    32'(timing_err), 32'd1);
    check("sat_unlock", 32'(locked),     32'd0);
    repeat (3000 - 2049) tick();
    check("sat_stay_unlocked", 32'(locked), 32'd0);
    check("sat_err_once", 32'(err_seen), 32'd1);
    check("sat_bad_strobes", 32'(bad), 32'd0);
    blank = 0;
    drive();
    run_until(0, 0); tick();
    run_until(0, 0); tick();
    check("sat_relock", 32'(locked), 32'd1);

    // Reset mid-line at pixel (8,4).
    run_until(VB + 4, HB + 1 + 8);
    check("rst_pre_valid", 32'(pix_valid), 32'd1);
    check("rst_pre_x", 32'(pix_x), 32'd7);
    check("rst_pre_y", 32'(pix_y), 32'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst");
    clear_mon();
    run_until(0, 0); tick();
    check("midrst_relock_1st", 32'(locked), 32'd0);
    run_until(0, 0); tick();
    check("midrst_relock_2nd", 32'(locked), 32'd1);
    check("midrst_no_strobes", 32'(strobes), 32'd0);
    check("midrst_line_len", 32'(line_len), 32'd31);
    check("midrst_frame_lines", 32'(frame_lines), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
